uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that sits directly downstream of the datapath's data-memory port (`dmem_addr`, `dmem_wdata`, `dmem_we`, `dmem_rdata`) alongside data RAM. A store to its TXDATA address pushes one byte into a transmit FIFO. A serializer drains the FIFO as 8N1 frames on `txd`. A load from STATUS returns FIFO and transmitter state. The address decoder outside this block muxes `rdata` into `dmem_rdata` whenever `sel` is high.

---
 rtl/uart_tx_mmio.sv | 159 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a transmit FIFO on the data-memory port.
// Latency: store at edge N pops at N+1 when idle; a frame then takes 10*CLK_DIV cycles.
// Backpressure: none on the store side; a store to a full FIFO is dropped and sets sticky overflow.
module uart_tx_mmio #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int              CLK_DIV    = 16,
    parameter int              FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    input  logic            we,
    output logic            sel,
    output logic [XLEN-1:0] rdata,
    output logic            txd
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int L  = PW + 1;
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        state, state_nx;
    logic [BW-1:0] baud, baud_nx;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [7:0]    shift, shift_nx;
    logic          pop;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [L-1:0]  count;
    logic          full, empty, overflow;
    logic          push_req, push, ovf_set, ovf_clr, tx_busy;

    // Bits of the bus this block never looks at.
    logic unused_bits;
    assign unused_bits = ^{wdata[XLEN-1:8], addr[1:0]};

    assign sel      = (addr[XLEN-1:3] == BASE_ADDR[XLEN-1:3]);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign tx_busy  = (state != S_IDLE);

    // Fullness is judged on pre-edge state, so a same-edge pop cannot rescue a store.
    assign push_req = we & sel & ~addr[2];
    assign push     = push_req & ~full;
    assign ovf_set  = push_req & full;
    assign ovf_clr  = we & sel & addr[2] & wdata[3];

    // Register read mux; TXDATA reads back as zero.
    always_comb begin
        rdata = '0;
        if (sel && addr[2]) begin
            rdata[0]     = full;
            rdata[1]     = empty;
            rdata[2]     = tx_busy;
            rdata[3]     = overflow;
            rdata[4 +: L] = count;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= wdata[7:0];
    end

    // FIFO pointers and the sticky overflow flag; a clear beats a same-edge set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (ovf_clr)      overflow <= 1'b0;
            else if (ovf_set) overflow <= 1'b1;
        end
    end

    // Serializer state and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_nx;
            baud    <= baud_nx;
            bit_cnt <= bit_cnt_nx;
            shift   <= shift_nx;
        end
    end

    // Serializer next state, FIFO pop and line level; STOP chains straight into START when data waits.
    always_comb begin
        state_nx   = state;
        baud_nx    = baud;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        pop        = 1'b0;
        txd        = 1'b1;
        case (state)
            S_IDLE: begin
                txd = 1'b1;
                if (!empty) begin
                    pop      = 1'b1;
                    shift_nx = mem[rd_ptr[PW-1:0]];
                    baud_nx  = BAUD_RELOAD;
                    state_nx = S_START;
                end
            end
            S_START: begin
                txd = 1'b0;
                if (baud == '0) begin
                    baud_nx    = BAUD_RELOAD;
                    bit_cnt_nx = 3'd0;
                    state_nx   = S_DATA;
                end else begin
                    baud_nx = baud - 1'b1;
                end
            end
            S_DATA: begin
                txd = shift[0];
                if (baud == '0) begin
                    shift_nx = {1'b0, shift[7:1]};
                    baud_nx  = BAUD_RELOAD;
                    if (bit_cnt == 3'd7) state_nx = S_STOP;
                    else                 bit_cnt_nx = bit_cnt + 1'b1;
                end else begin
                    baud_nx = baud - 1'b1;
                end
            end
            S_STOP: begin
                txd = 1'b1;
                if (baud == '0) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        shift_nx = mem[rd_ptr[PW-1:0]];
                        baud_nx  = BAUD_RELOAD;
                        state_nx = S_START;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end else begin
                    baud_nx = baud - 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Randomized and directed bench for uart_tx_mmio with a timing-level FIFO/transmitter model.
// Latency: frames are expected to start one edge after the model's pop decision.
// Backpressure: a line-level receiver decodes txd and checks each frame against a scoreboard.
module tb_uart_tx_mmio;

    localparam int CD    = 4;
    localparam int DEPTH = 4;
    localparam int L     = 3;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        sel;
    logic [31:0] rdata;
    logic        txd;

    uart_tx_mmio #(.XLEN(32), .BASE_ADDR(BASE), .CLK_DIV(CD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we),
        .sel(sel), .rdata(rdata), .txd(txd)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: accepted-but-unsent bytes, the edge at which the current frame ends,
    // and the sticky overflow flag.
    logic [7:0] mq[$];
    logic [7:0] sb_data[$];
    int         sb_time[$];
    int         frame_end = 0;
    int         ecnt = 0;
    logic       ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    function automatic logic in_win(input logic [31:0] a);
        return a[31:3] == BASE[31:3];
    endfunction

    function automatic logic [31:0] status_model();
        logic [31:0] s;
        s = '0;
        s[0] = (mq.size() == DEPTH);
        s[1] = (mq.size() == 0);
        s[2] = (frame_end > ecnt);
        s[3] = ovf;
        s[4 +: L] = L'(mq.size());
        return s;
    endfunction

    // Model of one rising edge: the transmitter takes the head once its previous frame is over.
    task automatic model_edge(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic full_pre;
        full_pre = (mq.size() == DEPTH);
        if (mq.size() > 0 && ecnt >= frame_end) begin
            void'(mq.pop_front());
            frame_end = ecnt + 10 * CD;
            sb_time.push_back(ecnt);
        end
        if (w && in_win(a) && !a[2]) begin
            if (full_pre) ovf = 1'b1;
            else begin
                mq.push_back(d[7:0]);
                sb_data.push_back(d[7:0]);
            end
        end
        if (w && in_win(a) && a[2] && d[3]) ovf = 1'b0;
    endtask

    // One bus cycle; entered just after a falling edge, returns just after the next one.
    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] exp_rd;
        we = w; addr = a; wdata = d;
        #1;
        exp_rd = (in_win(a) && a[2]) ? status_model() : 32'h0;
        chk("sel", {31'b0, sel}, {31'b0, in_win(a)});
        chk("rdata", rdata, exp_rd);
        @(posedge clk);
        ecnt++;
        model_edge(w, a, d);
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, BASE + 32'h4, 32'h0);
    endtask

    task automatic drain();
        int   lim;
        logic done;
        lim  = 10 * CD * (DEPTH + 2) + 20;
        done = 1'b0;
        for (int i = 0; i < lim && !done; i++) begin
            if (mq.size() == 0 && ecnt >= frame_end) done = 1'b1;
            else idle(1);
        end
        chk("drain_done", {31'b0, done}, 32'h1);
        idle(2);
    endtask

    // Asynchronous reset pulse mid-cycle; the line and STATUS must react before any edge.
    task automatic mid_reset();
        addr = BASE + 32'h4; we = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_txd", {31'b0, txd}, 32'h1);
        chk("rst_status", rdata, 32'h2);
        mq.delete(); sb_data.delete(); sb_time.delete();
        ovf = 1'b0; frame_end = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Line receiver: samples every cycle of a frame and requires each bit to be steady.
    initial begin
        logic [9:0]  bits;
        logic        steady, aborted;
        int          st;
        logic [7:0]  exp_b;
        forever begin
            @(negedge clk);
            if (reset && txd === 1'b0) begin
                st = ecnt; steady = 1'b1; aborted = 1'b0; bits = '0;
                for (int c = 0; c < 10 * CD; c++) begin
                    if (c != 0) begin
                        @(negedge clk);
                        if (!reset) aborted = 1'b1;
                    end
                    if (aborted) break;
                    if (c % CD == 0) bits[c / CD] = txd;
                    else if (txd !== bits[c / CD]) steady = 1'b0;
                end
                if (!aborted) begin
                    chk("frame_shape", {29'b0, steady, bits[0], bits[9]}, 32'h5);
                    if (sb_data.size() == 0 || sb_time.size() == 0) begin
                        n_vec++; n_bad++;
                        $display("FAIL unexpected_frame: got byte 0x%0h at edge %0d, expected no frame", bits[8:1], st);
                    end else begin
                        exp_b = sb_data.pop_front();
                        chk("frame_data", {24'b0, bits[8:1]}, {24'b0, exp_b});
                        chk("frame_start", st, sb_time.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int p;
        // Reset held: line idle, STATUS shows empty only.
        #1 reset = 1'b0;
        addr = BASE + 32'h4;
        #1;
        chk("reset_txd", {31'b0, txd}, 32'h1);
        chk("reset_status", rdata, 32'h2);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        idle(2);

        // Single byte, alternating pattern.
        step(1'b1, BASE, 32'h55);
        idle(10 * CD + 4);

        // Overflow: six back-to-back stores into a 4-deep FIFO, then clear the flag.
        for (int i = 0; i < 6; i++) step(1'b1, BASE, 32'hA0 + i);
        idle(2);
        step(1'b1, BASE + 32'h4, 32'h8);
        idle(2);
        drain();

        // Back-to-back frames.
        step(1'b1, BASE, 32'h00);
        step(1'b1, BASE, 32'hFF);
        drain();

        // Address decode: outside the window, and TXDATA reads.
        step(1'b1, BASE + 32'h8, 32'h77);
        step(1'b0, BASE, 32'h0);
        step(1'b0, BASE + 32'h8, 32'h0);
        idle(3);

        // Reset during DATA bit 3 of 0xC3 (bit 3 is 0).
        step(1'b1, BASE, 32'hC3);
        idle(4 * CD + 2);
        #1;
        chk("pre_reset_txd", {31'b0, txd}, 32'h0);
        mid_reset();
        idle(12 * CD);

        // Randomized traffic in blocks with varying store density.
        for (int blk = 0; blk < 20; blk++) begin
            p = $urandom_range(1, 15);
            for (int i = 0; i < 100; i++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < p)
                    step(1'b1, BASE | 32'($urandom_range(0, 3)), $urandom);
                else if (r < p + 3)
                    step(1'b1, (BASE + 32'h4) | 32'($urandom_range(0, 3)), $urandom);
                else if (r < p + 6)
                    step(1'b1, $urandom, $urandom);
                else if (r < p + 15)
                    step(1'b0, BASE, $urandom);
                else
                    step(1'b0, BASE + 32'h4, 32'h0);
            end
        end
        drain();
        chk("sb_empty", sb_data.size() + sb_time.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
